// File: rtl/jogo_memoria_param_if.sv
// Player/board-side signal bundle of the memory game core.
// master = board side (buttons, start, config); slave = game core.
interface jogo_memoria_param_if #(
    parameter int N_BOTOES    = 4,
    parameter int MAX_RODADAS = 16
);
    logic                         jogar;
    logic [1:0]                   configuracao;
    logic [N_BOTOES-1:0]          botoes;
    logic [N_BOTOES-1:0]          leds;
    logic                         pronto;
    logic                         ganhou;
    logic                         perdeu;
    logic                         timeout;
    logic [$clog2(MAX_RODADAS):0] rodada;
    logic [3:0]                   db_estado;

    modport master (
        output jogar, configuracao, botoes,
        input  leds, pronto, ganhou, perdeu, timeout, rodada, db_estado
    );
    modport slave (
        input  jogar, configuracao, botoes,
        output leds, pronto, ganhou, perdeu, timeout, rodada, db_estado
    );
endinterface

// File: rtl/jogo_memoria_param.sv
// Memory-challenge game core: shows a growing one-hot sequence, then checks presses.
// JOGO_MEMORIA_LFSR_EN selects LFSR-generated elements instead of the fixed rotation.
module jogo_memoria_param #(
    parameter int N_BOTOES     = 4,
    parameter int MAX_RODADAS  = 16,
    parameter int RODADAS_DEMO = 4,
    parameter int T_LED        = 50000000,
    parameter int T_APAGADO    = 25000000,
    parameter int T_TIMEOUT    = 250000000
) (
    input logic                  clock,
    input logic                  reset,
    jogo_memoria_param_if.slave  io
);
    localparam int AW   = $clog2(MAX_RODADAS) + 1;
    localparam int IW   = $clog2(MAX_RODADAS);
    localparam int TMAX = (T_LED > T_APAGADO) ? T_LED : T_APAGADO;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int TOW  = $clog2(T_TIMEOUT + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        NOVO_ELEM      = 4'd2,
        MOSTRA_LED     = 4'd3,
        PROX_LED       = 4'd4,
        MOSTRA_APAGADO = 4'd5,
        ESPERA         = 4'd7,
        REGISTRA       = 4'd8,
        COMPARA        = 4'd9,
        PROX_JOGADA    = 4'd10,
        GANHOU         = 4'd11,
        FIM_RODADA     = 4'd13,
        PERDEU         = 4'd14,
        TIMEOUT        = 4'd15
    } estado_t;

    estado_t             estado;
    logic [AW-1:0]       endereco, limite, alvo;
    logic                to_en;
    logic [TW-1:0]       tmr;
    logic [TOW-1:0]      tcnt;
    logic [N_BOTOES-1:0] jogada, botoes_q, novo;
    logic [N_BOTOES-1:0] mem [MAX_RODADAS];
    logic                borda;

    function automatic logic [N_BOTOES-1:0] um_quente(input int k);
        return N_BOTOES'(1) << (k % N_BOTOES);
    endfunction

`ifdef JOGO_MEMORIA_LFSR_EN
    logic [15:0] lfsr;
    // Galois form of x^16+x^14+x^13+x^11+1, free-running so the sequence depends on start time
    always_ff @(posedge clock or negedge reset)
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign novo = um_quente(int'(lfsr));
`else
    assign novo = um_quente(int'(limite));
`endif

    always_ff @(posedge clock or negedge reset)
        if (!reset) botoes_q <= '0;
        else        botoes_q <= io.botoes;

    // Only an all-released -> any-pressed transition counts, so a held button fires once
    assign borda = (|io.botoes) & ~(|botoes_q);
    assign io.db_estado = estado;

    always_ff @(posedge clock)
        if (estado == NOVO_ELEM) mem[limite[IW-1:0]] <= novo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= INICIAL;
            endereco   <= '0;
            limite     <= '0;
            alvo       <= '0;
            to_en      <= 1'b0;
            tmr        <= '0;
            tcnt       <= '0;
            jogada     <= '0;
            io.leds    <= '0;
            io.pronto  <= 1'b0;
            io.ganhou  <= 1'b0;
            io.perdeu  <= 1'b0;
            io.timeout <= 1'b0;
            io.rodada  <= '0;
        end else begin
            case (estado)
                INICIAL: begin
                    io.rodada <= '0;
                    if (io.jogar) estado <= PREPARA;
                end
                PREPARA: begin
                    endereco  <= '0;
                    limite    <= '0;
                    tmr       <= '0;
                    tcnt      <= '0;
                    alvo      <= io.configuracao[0] ? AW'(RODADAS_DEMO) : AW'(MAX_RODADAS);
                    to_en     <= io.configuracao[1];
                    io.rodada <= '0;
                    io.leds   <= '0;
                    estado    <= NOVO_ELEM;
                end
                NOVO_ELEM: begin
                    endereco  <= '0;
                    tmr       <= '0;
                    io.rodada <= limite + AW'(1);
                    // mem[0] is being written this cycle in round 1, so forward it
                    io.leds   <= (limite == '0) ? novo : mem[0];
                    estado    <= MOSTRA_LED;
                end
                MOSTRA_LED: begin
                    if (tmr == TW'(T_LED - 1)) begin
                        tmr     <= '0;
                        io.leds <= '0;
                        estado  <= MOSTRA_APAGADO;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                MOSTRA_APAGADO: begin
                    if (tmr == TW'(T_APAGADO - 1)) begin
                        tmr <= '0;
                        if (endereco < limite) begin
                            estado <= PROX_LED;
                        end else begin
                            endereco <= '0;
                            tcnt     <= '0;
                            estado   <= ESPERA;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                PROX_LED: begin
                    endereco <= endereco + AW'(1);
                    io.leds  <= mem[IW'(endereco + AW'(1))];
                    estado   <= MOSTRA_LED;
                end
                ESPERA: begin
                    if (borda) begin
                        jogada  <= io.botoes;
                        io.leds <= io.botoes;
                        estado  <= REGISTRA;
                    end else if (to_en && tcnt == TOW'(T_TIMEOUT - 1)) begin
                        io.timeout <= 1'b1;
                        io.pronto  <= 1'b1;
                        estado     <= TIMEOUT;
                    end else if (tcnt != TOW'(T_TIMEOUT - 1)) begin
                        tcnt <= tcnt + TOW'(1);
                    end
                end
                REGISTRA: begin
                    io.leds <= '0;
                    estado  <= COMPARA;
                end
                COMPARA: begin
                    // stored elements are one-hot, so a multi-button press never matches
                    if (jogada == mem[endereco[IW-1:0]]) begin
                        estado <= (endereco < limite) ? PROX_JOGADA : FIM_RODADA;
                    end else begin
                        io.perdeu <= 1'b1;
                        io.pronto <= 1'b1;
                        estado    <= PERDEU;
                    end
                end
                PROX_JOGADA: begin
                    endereco <= endereco + AW'(1);
                    tcnt     <= '0;
                    estado   <= ESPERA;
                end
                FIM_RODADA: begin
                    if (limite + AW'(1) == alvo) begin
                        io.ganhou <= 1'b1;
                        io.pronto <= 1'b1;
                        estado    <= GANHOU;
                    end else begin
                        limite <= limite + AW'(1);
                        estado <= NOVO_ELEM;
                    end
                end
                GANHOU, PERDEU, TIMEOUT: begin
                    if (io.jogar) begin
                        io.pronto  <= 1'b0;
                        io.ganhou  <= 1'b0;
                        io.perdeu  <= 1'b0;
                        io.timeout <= 1'b0;
                        estado     <= PREPARA;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end
endmodule

// File: doc/jogo_memoria_param.md
Name: jogo_memoria_param

Overview:
- Parametrised successor of the memory-challenge game core: presents a growing sequence on N one-hot LEDs, then checks the player's button presses against it.
- Adds over the previous generation: configurable button count, round depth and timing; edge-detected input capture; multi-button press treated as an error; round counter output.
- Sits between board debouncers and LED/7-segment drivers; one clock domain.

Parameters:
- N_BOTOES, 4, number of buttons/LEDs (2..8).
- MAX_RODADAS, 16, rounds needed to win in full mode (2..64).
- RODADAS_DEMO, 4, rounds needed to win in demo mode (1..MAX_RODADAS).
- T_LED, 50000000, cycles an LED is lit during presentation.
- T_APAGADO, 25000000, cycles of dark gap after each LED.
- T_TIMEOUT, 250000000, cycles allowed per press when timeout is enabled.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- jogar  in  1  start/restart game; level sampled in INICIAL and in final states.
- configuracao  in  2  [0]=1 demo mode (RODADAS_DEMO rounds), [1]=1 timeout enabled; latched at game start.
- botoes  in  N_BOTOES  debounced buttons, active-high.
- leds  out  N_BOTOES  one-hot presentation output; echoes the captured press for 1 cycle in REGISTRA.
- pronto  out  1  high in GANHOU, PERDEU and TIMEOUT.
- ganhou  out  1  high in GANHOU.
- perdeu  out  1  high in PERDEU.
- timeout  out  1  high in TIMEOUT.
- rodada  out  $clog2(MAX_RODADAS)+1  current round number, 1-based; 0 when idle.
- db_estado  out  4  state encoding.

Behaviour:
- Reset (reset=0, async): state INICIAL; all outputs 0; all counters 0; the LFSR reloads its seed.
- States and encodings:
  - INICIAL 0: leave when jogar=1.
  - PREPARA 1: clear counters, latch configuracao, limite=0.
  - NOVO_ELEM 2: write a new one-hot element at address limite (LFSR or fixed per macro); endereco=0.
  - MOSTRA_LED 3: leds=mem[endereco] for T_LED cycles.
  - MOSTRA_APAGADO 5: leds=0 for T_APAGADO cycles; go to PROX_LED 4 (endereco+1) if endereco<limite, else to ESPERA with endereco=0.
  - ESPERA 7: wait for a rising edge of |botoes.
  - REGISTRA 8: capture the press.
  - COMPARA 9: correct → PROX_JOGADA 10 if endereco<limite, else FIM_RODADA 13; wrong → PERDEU 14.
  - PROX_JOGADA 10: endereco+1, then ESPERA.
  - FIM_RODADA 13: limite+1 == target rounds → GANHOU 11; else limite+1 and back to NOVO_ELEM.
  - GANHOU 11, PERDEU 14, TIMEOUT 15: hold until jogar=1, then PREPARA (no reset needed).
- Input capture: botoes registered once; edge = (|botoes) & ~(|botoes_q).
  - Captured value not one-hot (more than one bit set) → mismatch → PERDEU.
  - Holding a button generates no further presses until all buttons are released.
- Timeout: counter runs only in ESPERA, cleared on entry to ESPERA.
  - Reaching T_TIMEOUT-1 with configuracao[1]=1 → TIMEOUT.
  - With configuracao[1]=0 the counter saturates and is ignored.
  - Edge and timeout expiry in the same cycle: the edge wins.
- rodada = limite+1 from NOVO_ELEM onward; retains its value in the final states; cleared in PREPARA and INICIAL.
- Presentation timers and the timeout counter are independent and each cleared on state entry.
- Latency: PROX_LED, PROX_JOGADA, NOVO_ELEM, REGISTRA and COMPARA each take 1 cycle.

Optional Feature:
- JOGO_MEMORIA_LFSR_EN defined: elements come from a 16-bit maximal LFSR (seed 16'hACE1) stepping every clock; the new element is the one-hot of lfsr mod N_BOTOES.
- Undefined: element k = one-hot(k mod N_BOTOES), i.e. 0001,0010,0100,1000,0001... for N_BOTOES=4.

Test Plan (macro undefined, N_BOTOES=4, MAX_RODADAS=16, RODADAS_DEMO=4, T_LED=4, T_APAGADO=2, T_TIMEOUT=50):
- Demo win: configuracao=01, pulse jogar, press the correct sequence each round → ganhou=1 after round 4, rodada=4, db_estado=11.
- Wrong press: round 1, press 1000 → perdeu=1, pronto=1, db_estado=14.
- Timeout: configuracao=11, no press after presentation → timeout=1 exactly 50 cycles after entering ESPERA.
- Timeout disabled: configuracao=00, idle 1000 cycles then press 0001 → state reaches 13, no timeout.
- Multi-press and held button: press 0011 → perdeu=1. Separately, hold 0001 across two expected presses → only one press registered, game stays in ESPERA.
- Restart and async reset: after PERDEU, pulse jogar → rodada=1 and a fresh round-1 presentation. Assert reset=0 mid-MOSTRA_LED → db_estado=0 and leds=0 immediately, without waiting for a clock edge.
